// File: rtl/qupls_regfile_wb_arb.sv
// Writeback arbiter for a register file RAM write port.
// Each source has its own small FIFO. A round-robin pick drains one entry per cycle into a registered write stage.
module qupls_regfile_wb_arb #(
  parameter int NSRC    = 4,
  parameter int QDEP    = 2,
  parameter int AWID    = 9,
  parameter int DWID    = 65,
  parameter int DROP_P0 = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NSRC-1:0]                   src_v,
  output logic [NSRC-1:0]                   src_rdy,
  input  logic [NSRC*AWID-1:0]              src_addr,
  input  logic [NSRC*DWID-1:0]              src_data,
  output logic                              ram_ena,
  output logic                              ram_wea,
  output logic [AWID-1:0]                   ram_addra,
  output logic [DWID-1:0]                   ram_dina,
  output logic                              wb_v,
  output logic [AWID-1:0]                   wb_addr,
  output logic [$clog2(NSRC*QDEP+1)-1:0]    pend,
  output logic                              idle
);

  localparam int QAW = (QDEP > 1) ? $clog2(QDEP) : 1;
  localparam int CW  = $clog2(QDEP + 1);
  localparam int SW  = $clog2(NSRC);
  localparam int PW  = $clog2(NSRC*QDEP + 1);

  logic [AWID-1:0] q_addr [NSRC][QDEP];
  logic [DWID-1:0] q_data [NSRC][QDEP];
  logic [QAW-1:0]  wr_ptr [NSRC];
  logic [QAW-1:0]  rd_ptr [NSRC];
  logic [CW-1:0]   cnt    [NSRC];

  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;
  logic [NSRC-1:0] full;
  logic            grant;
  logic [SW-1:0]   winner;
  logic [SW-1:0]   rr;
  logic [AWID-1:0] win_addr;
  logic [DWID-1:0] win_data;
  logic            wr_v;

  // Ready is based only on the registered count. A full FIFO stays not-ready even while it is being popped.
  for (genvar i = 0; i < NSRC; i++) begin : g_hs
    assign full[i]    = (cnt[i] == CW'(QDEP));
    assign src_rdy[i] = ~rst & ~full[i];
    assign push[i]    = src_v[i] & src_rdy[i];
    assign pop[i]     = grant & (winner == SW'(i));
  end

  always_comb begin
    grant  = 1'b0;
    winner = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (!grant && cnt[(int'(rr) + k) % NSRC] != '0) begin
        grant  = 1'b1;
        winner = SW'((int'(rr) + k) % NSRC);
      end
    end
  end

  assign win_addr = q_addr[winner][rd_ptr[winner]];
  assign win_data = q_data[winner][rd_ptr[winner]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= '0;
    end else if (grant) begin
      rr <= (winner == SW'(NSRC-1)) ? '0 : winner + SW'(1);
    end
  end

  // QDEP is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + QAW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + QAW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) begin
        q_addr[i][wr_ptr[i]] <= src_addr[i*AWID +: AWID];
        q_data[i][wr_ptr[i]] <= src_data[i*DWID +: DWID];
      end
    end
  end

  // A popped write to p0 is discarded. Its strobes stay low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_v      <= 1'b0;
      ram_addra <= '0;
      ram_dina  <= '0;
    end else begin
      wr_v <= grant & ~((DROP_P0 != 0) && (win_addr == '0));
      if (grant) begin
        ram_addra <= win_addr;
        ram_dina  <= win_data;
      end
    end
  end

  assign ram_ena = wr_v;
  assign ram_wea = wr_v;
  assign wb_v    = wr_v;
  assign wb_addr = ram_addra;

  always_comb begin
    pend = '0;
    for (int i = 0; i < NSRC; i++) pend = pend + PW'(cnt[i]);
  end

  assign idle = (pend == '0) & ~wr_v;

endmodule
